input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Multi-channel debouncer and edge-pulse generator for the raw push-button and sensor inputs.
- Sits directly upstream of the Synchronizer stage of the traffic-light controller.
- Each channel does its own 2-FF synchronisation, then a per-channel counter FSM.
- Outputs are a clean level plus single-cycle press/release pulses, which feed Sensor / Walk_Request / Reprogram downstream.

Parameters:
- N_CH, 3, number of independent input channels (bit 0 Sensor, bit 1 Walk_Request, bit 2 Reprogram).
- CNT_W, 16, width of each channel's debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES, 50000, consecutive equal synchronised samples required to accept a new level; legal range 2..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all flops rise-edge.
- Reset_Sync  input  1  synchronous active-high reset.
- raw_in  input  N_CH  asynchronous raw switch/sensor levels.
- level_out  output  N_CH  debounced level per channel.
- press_pulse  output  N_CH  one-cycle pulse on an accepted 0->1 transition.
- release_pulse  output  N_CH  one-cycle pulse on an accepted 1->0 transition.

Behaviour:
- Sync stage per channel: s1 <= raw_in[i]; s2 <= s1. Both reset to 0.
- Per-channel FSM states: STABLE_LO, ARM_HI, STABLE_HI, ARM_LO. Reset state is STABLE_LO with cnt = 0.
- STABLE_LO:
  - s2 = 1 -> ARM_HI, cnt <= 1.
  - Otherwise stay, cnt <= 0.
- ARM_HI:
  - s2 = 0 -> STABLE_LO, cnt <= 0. Glitch is rejected; no pulse.
  - s2 = 1 and cnt = DEBOUNCE_CYCLES-1 -> STABLE_HI, level_out[i] <= 1, press_pulse[i] <= 1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- STABLE_HI and ARM_LO: mirror of the above with polarity inverted. Acceptance sets level_out[i] <= 0 and release_pulse[i] <= 1.
- Latency:
  - level_out changes on the same edge that registers the DEBOUNCE_CYCLES-th consecutive equal s2 sample.
  - Raw-edge-to-output latency is exactly DEBOUNCE_CYCLES+2 clk cycles.
- Pulses are registered and last exactly one cycle; they are 0 in every other cycle.
- press_pulse and release_pulse are never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- The counter never wraps: it is cleared on acceptance and on glitch rejection, so it never exceeds DEBOUNCE_CYCLES-1.
- Reset_Sync:
  - Highest priority, applies every cycle, including mid-count.
  - Forces s1, s2, cnt, state and all outputs to 0 / STABLE_LO on the next edge.
  - An input held high through reset release is debounced from scratch and then produces one press_pulse.
- A bounce of length k < DEBOUNCE_CYCLES in s2 produces no output change.

Optional Feature:
- Macro: INPUT_DEBOUNCER_REPEAT_EN.
- When defined:
  - Adds parameter REPEAT_CYCLES (default 500000) and a per-channel repeat counter of width CNT_W+4.
  - While in STABLE_HI, the counter increments each cycle. On reaching REPEAT_CYCLES-1 it emits one extra press_pulse cycle and clears.
  - The repeat counter is cleared on leaving STABLE_HI and on Reset_Sync.
- When undefined: no repeat logic; press_pulse fires once per accepted press. Port list is identical in both builds.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=3, N_CH=3, REPEAT_CYCLES=10):
- Reset: assert Reset_Sync for 3 cycles with raw_in=3'b111, then release -> level_out=0 and pulses=0 during reset; level_out=3'b111 exactly 6 cycles after release, with press_pulse=3'b111 for 1 cycle.
- Clean press/release: raw_in[1] 0->1, hold 10 cycles, then 1->0 -> level_out[1] rises 6 cycles after the edge with a 1-cycle press_pulse[1]; falls 6 cycles after the release edge with a 1-cycle release_pulse[1].
- Bounce rejection: raw_in[0] toggles 1,0,1,1,0,1 (one cycle each), then holds 0 -> level_out[0] stays 0 and no pulses.
- Reset mid-count: raw_in[2]=1 for 3 cycles, assert Reset_Sync for 1 cycle, keep raw high -> no pulse before reset; after reset, press_pulse[2] fires 6 cycles after the reset edge.
- Simultaneous channels: raw_in 000->101 in the same cycle -> press_pulse=3'b101 in one cycle; channel 1 untouched.
- Repeat (INPUT_DEBOUNCER_REPEAT_EN): hold raw_in[1]=1 for 40 cycles -> initial press_pulse[1] followed by repeat pulses every 10 cycles (3 repeats), none after release; the build without the macro shows 1 pulse only.

Source files
------------

// File: rtl/input_debouncer_if.sv
// -----------------------------------------------------------------------------
// input_debouncer_if
//
// Purpose:
//   Groups the input_debouncer's per-channel signals into one bundle. The raw
//   switch/sensor levels go in, and the cleaned level plus the press/release
//   pulses come out.
//
// Signals (all N_CH wide, bit 0 Sensor, bit 1 Walk_Request, bit 2 Reprogram):
//   raw_in        asynchronous raw levels from the switches/sensors
//   level_out     debounced level per channel
//   press_pulse   one-cycle pulse on an accepted 0->1 transition
//   release_pulse one-cycle pulse on an accepted 1->0 transition
//
// Modports:
//   master  side that supplies raw_in and consumes the debounced results
//   slave   the debouncer itself (samples raw_in, drives the results)
// -----------------------------------------------------------------------------
interface input_debouncer_if #(
  parameter int N_CH = 3
);

  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;

  modport master (
    output raw_in,
    input  level_out,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  raw_in,
    output level_out,
    output press_pulse,
    output release_pulse
  );

endinterface

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Purpose:
//   This is a multi-channel debouncer and edge-pulse generator for the raw
//   push-button and sensor inputs of the traffic-light controller. Each
//   channel first passes through its own 2-FF synchroniser. A four-state
//   counter FSM then accepts a new level only after DEBOUNCE_CYCLES
//   consecutive equal synchronised samples. On acceptance the FSM updates
//   the clean level and emits a one-cycle press or release pulse.
//
// Ports:
//   clk         system clock; every flop is rising-edge triggered
//   Reset_Sync  synchronous active-high reset, highest priority
//   bus         input_debouncer_if.slave carrying raw_in, level_out,
//               press_pulse and release_pulse (N_CH bits each)
//
// Parameters:
//   N_CH             number of independent channels
//   CNT_W            debounce counter width; 2**CNT_W must exceed
//                    DEBOUNCE_CYCLES
//   DEBOUNCE_CYCLES  consecutive equal samples needed to accept a level
//                    (2 .. 2**CNT_W-1)
//   REPEAT_CYCLES    auto-repeat period; exists only when the
//                    INPUT_DEBOUNCER_REPEAT_EN build option is defined
//
// Build option:
//   INPUT_DEBOUNCER_REPEAT_EN
//     When defined, a channel held in its stable-high state re-emits a
//     press_pulse every REPEAT_CYCLES cycles. When undefined, there is exactly
//     one press_pulse per accepted press. The port list is the same in both
//     builds.
//
// Timing:
//   The raw edge reaches level_out exactly DEBOUNCE_CYCLES+2 cycles after the
//   edge. The synchroniser adds 2 cycles, and the FSM needs DEBOUNCE_CYCLES
//   equal samples.
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int N_CH            = 3,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
`ifdef INPUT_DEBOUNCER_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 500000
`endif
) (
  input  logic                clk,
  input  logic                Reset_Sync,
  input_debouncer_if.slave    bus
);

  // Per-channel FSM encoding. The low bit marks the "arming" states in which
  // the counter is measuring a candidate new level.
  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] ARM_HI    = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] ARM_LO    = 2'd3;

  // The counter value at which the DEBOUNCE_CYCLES-th equal sample is seen.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef INPUT_DEBOUNCER_REPEAT_EN
  // The repeat counter is 4 bits wider than the debounce counter. This makes
  // the repeat period much longer than the debounce time.
  localparam int                REP_W    = CNT_W + 4;
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  // Each channel drives one bit of these vectors, and the vectors then drive
  // the interface outputs.
  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] press_vec;
  logic [N_CH-1:0] release_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level;
    logic             level_next;
    logic             press;
    logic             press_next;
    logic             press_all;
    logic             rel;
    logic             rel_next;

    // Two-flop synchroniser. raw_in is asynchronous, so nothing downstream
    // looks at it before s2.
    always_ff @(posedge clk) begin
      if (Reset_Sync) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= bus.raw_in[i];
        s2 <= s1;
      end
    end

    // Next-state logic of the debounce FSM. In a stable state, a differing
    // sample counts as the first of a run (cnt <= 1). In an arming state, a
    // sample equal to the old level rejects the run as a glitch. The
    // DEBOUNCE_CYCLES-th consecutive differing sample accepts the new level
    // and raises the matching pulse. The counter is cleared on every exit
    // from an arming state, so it never exceeds CNT_LAST.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      level_next = level;
      press_next = 1'b0;
      rel_next   = 1'b0;
      case (state)
        STABLE_LO: begin
          if (s2) begin
            state_next = ARM_HI;
            cnt_next   = CNT_ONE;
          end else begin
            cnt_next   = '0;
          end
        end
        ARM_HI: begin
          if (!s2) begin
            state_next = STABLE_LO;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = STABLE_HI;
            level_next = 1'b1;
            press_next = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next   = cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            state_next = ARM_LO;
            cnt_next   = CNT_ONE;
          end else begin
            cnt_next   = '0;
          end
        end
        ARM_LO: begin
          if (s2) begin
            state_next = STABLE_HI;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = STABLE_LO;
            level_next = 1'b0;
            rel_next   = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next   = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = STABLE_LO;
          cnt_next   = '0;
          level_next = 1'b0;
        end
      endcase
    end

`ifdef INPUT_DEBOUNCER_REPEAT_EN
    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_next;
    logic             rep_fire;

    // Auto-repeat timer. It runs only while the channel stays in STABLE_HI.
    // A cycle that leaves STABLE_HI (s2 low) clears it instead of firing, so
    // a repeat pulse never lands on the cycle of a release.
    always_comb begin
      rep_next = '0;
      rep_fire = 1'b0;
      if (state == STABLE_HI && s2) begin
        if (rep == REP_LAST) begin
          rep_fire = 1'b1;
        end else begin
          rep_next = rep + REP_ONE;
        end
      end
    end

    // Register the repeat timer. Reset_Sync clears it.
    always_ff @(posedge clk) begin
      if (Reset_Sync) begin
        rep <= '0;
      end else begin
        rep <= rep_next;
      end
    end

    assign press_all = press_next | rep_fire;
`else
    assign press_all = press_next;
`endif

    // Register the FSM state, the counter, the clean level and the pulses.
    // The pulses are registered, so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
      if (Reset_Sync) begin
        state <= STABLE_LO;
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
        level <= level_next;
        press <= press_all;
        rel   <= rel_next;
      end
    end

    assign level_vec[i]   = level;
    assign press_vec[i]   = press;
    assign release_vec[i] = rel;

  end : g_ch

  assign bus.level_out     = level_vec;
  assign bus.press_pulse   = press_vec;
  assign bus.release_pulse = release_vec;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Purpose:
//   Self-checking bench for input_debouncer with N_CH=3, CNT_W=3,
//   DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=10. REPEAT_CYCLES applies only when
//   INPUT_DEBOUNCER_REPEAT_EN is defined.
//
//   A behavioural model tracks, per channel, the accepted level and the
//   length of the current run of synchronised samples that disagree with it.
//   A run of DEBOUNCE_CYCLES such samples flips the level and raises a pulse.
//   The bench checks every cycle against this model. Directed scenarios add
//   timing and pulse-count checks against fixed expected numbers.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_input_debouncer;

  localparam int N_CH  = 3;
  localparam int CNT_W = 3;
  localparam int DEB   = 4;
  localparam int REP   = 10;

  logic clk;
  logic Reset_Sync;

  input_debouncer_if #(.N_CH(N_CH)) dut_if ();

  input_debouncer #(
    .N_CH            (N_CH),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEB)
`ifdef INPUT_DEBOUNCER_REPEAT_EN
    ,
    .REPEAT_CYCLES   (REP)
`endif
  ) dut (
    .clk        (clk),
    .Reset_Sync (Reset_Sync),
    .bus        (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state for each channel:
  //   m_d1 / m_d2  two-cycle delay of raw_in
  //   m_lvl        accepted level
  //   m_run        consecutive samples that disagree with m_lvl
  //   m_age        cycles spent in stable-high, for the repeat timer
  int m_d1  [N_CH];
  int m_d2  [N_CH];
  int m_lvl [N_CH];
  int m_run [N_CH];
  int m_age [N_CH];
  logic [N_CH-1:0] exp_level;
  logic [N_CH-1:0] exp_press;
  logic [N_CH-1:0] exp_rel;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Advance the behavioural model by one clock edge.
  task automatic modelEdge(input logic rst, input logic [N_CH-1:0] raw);
    int sample;
    bit was_stable_hi;
    for (int ch = 0; ch < N_CH; ch++) begin
      exp_press[ch] = 1'b0;
      exp_rel[ch]   = 1'b0;
      if (rst) begin
        m_d1[ch] = 0; m_d2[ch] = 0; m_lvl[ch] = 0; m_run[ch] = 0; m_age[ch] = 0;
      end else begin
        sample    = m_d2[ch];
        m_d2[ch]  = m_d1[ch];
        m_d1[ch]  = int'(raw[ch]);
        was_stable_hi = (m_lvl[ch] == 1) && (m_run[ch] == 0);
        if (sample != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_lvl[ch] = sample;
            m_run[ch] = 0;
            if (sample == 1) exp_press[ch] = 1'b1;
            else             exp_rel[ch]   = 1'b1;
          end
        end else begin
          m_run[ch] = 0;
        end
`ifdef INPUT_DEBOUNCER_REPEAT_EN
        if (was_stable_hi && sample == 1) begin
          if (m_age[ch] == REP - 1) begin
            exp_press[ch] = 1'b1;
            m_age[ch]     = 0;
          end else begin
            m_age[ch]++;
          end
        end else begin
          m_age[ch] = 0;
        end
`endif
      end
      exp_level[ch] = m_lvl[ch][0];
    end
  endtask

  // Drive one cycle of inputs, step the model, then check all outputs
  // 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic [N_CH-1:0] raw);
    Reset_Sync    = rst;
    dut_if.raw_in = raw;
    @(posedge clk);
    modelEdge(rst, raw);
    #1;
    checkOutput("level_out",     32'(dut_if.level_out),     32'(exp_level));
    checkOutput("press_pulse",   32'(dut_if.press_pulse),   32'(exp_press));
    checkOutput("release_pulse", 32'(dut_if.release_pulse), 32'(exp_rel));
  endtask

  // Put the DUT and model into a clean reset state.
  task automatic doReset();
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
  endtask

  int press_cnt;
  int rel_cnt;
  int press_at;
  int rel_at;
  int hold [N_CH];
  logic [N_CH-1:0] rnd_raw;
  logic [5:0] bounce;

  initial begin
    Reset_Sync    = 1'b1;
    dut_if.raw_in = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      m_d1[ch] = 0; m_d2[ch] = 0; m_lvl[ch] = 0; m_run[ch] = 0; m_age[ch] = 0;
    end
    exp_level = '0; exp_press = '0; exp_rel = '0;

    // Reset held with all inputs high, then released.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 3'b111);
      checkOutput("rst_level", 32'(dut_if.level_out), 32'd0);
      checkOutput("rst_press", 32'(dut_if.press_pulse), 32'd0);
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 3'b111);
      checkOutput("rst_rel_level", 32'(dut_if.level_out), (k >= 6) ? 32'h7 : 32'h0);
      checkOutput("rst_rel_press", 32'(dut_if.press_pulse), (k == 6) ? 32'h7 : 32'h0);
    end

    // Clean press and release on channel 1.
    doReset();
    press_cnt = 0; rel_cnt = 0; press_at = -1; rel_at = -1;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 3'b010);
      if (dut_if.press_pulse[1]) begin press_cnt++; press_at = k; end
    end
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 3'b000);
      if (dut_if.release_pulse[1]) begin rel_cnt++; rel_at = k; end
    end
    checkOutput("clean_press_cnt", 32'(press_cnt), 32'd1);
    checkOutput("clean_press_at",  32'(press_at),  32'd6);
    checkOutput("clean_rel_cnt",   32'(rel_cnt),   32'd1);
    checkOutput("clean_rel_at",    32'(rel_at),    32'd6);

    // Bounce on channel 0: 1,0,1,1,0,1 and then a steady 0.
    doReset();
    bounce = 6'b101101;
    press_cnt = 0; rel_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, (k < 6) ? {2'b00, bounce[5-k]} : 3'b000);
      if (dut_if.press_pulse[0] || dut_if.level_out[0]) press_cnt++;
      if (dut_if.release_pulse[0]) rel_cnt++;
    end
    checkOutput("bounce_press", 32'(press_cnt), 32'd0);
    checkOutput("bounce_rel",   32'(rel_cnt),   32'd0);

    // Reset in the middle of a count on channel 2.
    doReset();
    press_cnt = 0; press_at = -1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'b100);
      if (dut_if.press_pulse[2]) press_cnt++;
    end
    applyStimulus(1'b1, 3'b100);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b0, 3'b100);
      if (dut_if.press_pulse[2]) begin press_cnt++; press_at = k; end
    end
    checkOutput("midrst_press_cnt", 32'(press_cnt), 32'd1);
    checkOutput("midrst_press_at",  32'(press_at),  32'd6);

    // Simultaneous press on channels 0 and 2.
    doReset();
    press_at = -1;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 3'b101);
      if (dut_if.press_pulse != 3'b000) begin
        checkOutput("simul_press_val", 32'(dut_if.press_pulse), 32'h5);
        press_at = k;
      end
    end
    checkOutput("simul_press_at", 32'(press_at), 32'd6);
    checkOutput("simul_level",    32'(dut_if.level_out), 32'h5);

    // Long hold on channel 1, which exercises auto-repeat.
    doReset();
    press_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 3'b010);
      if (dut_if.press_pulse[1]) press_cnt++;
    end
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 3'b000);
      if (dut_if.press_pulse[1]) press_cnt++;
    end
`ifdef INPUT_DEBOUNCER_REPEAT_EN
    checkOutput("repeat_press_cnt", 32'(press_cnt), 32'd4);
`else
    checkOutput("repeat_press_cnt", 32'(press_cnt), 32'd1);
`endif

    // Randomised phase: every channel holds each random level for a random
    // number of cycles, with an occasional reset.
    doReset();
    rnd_raw = '0;
    for (int ch = 0; ch < N_CH; ch++) hold[ch] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (hold[ch] == 0) begin
          rnd_raw[ch] = 1'($urandom_range(0, 1));
          hold[ch]    = $urandom_range(1, 14);
        end else begin
          hold[ch]--;
        end
      end
      applyStimulus(($urandom_range(0, 99) == 0), rnd_raw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
